// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: FSM encodings, parity selectors
// and the serial line levels.
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Holds the accepted word and the bit index for the TX framer. It exposes bit 0,
// the bit after the current index, and a flag that is set when the current bit is the last one.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  advance,
  input  logic [DATA_WIDTH-1:0] p_data,
  output logic                  first_bit,
  output logic                  next_bit,
  output logic                  last_bit
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] data_reg;
  logic [IDX_W-1:0]      bit_idx;
  logic [IDX_W-1:0]      idx_inc;

  assign idx_inc = bit_idx + IDX_W'(1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_reg <= '0;
      bit_idx  <= '0;
    end else if (load) begin
      data_reg <= p_data;
      bit_idx  <= '0;
    end else if (advance) begin
      bit_idx <= idx_inc;
    end
  end

  // TX_OUT is registered, so the framer loads the bit after the current one.
  assign first_bit = data_reg[0];
  assign next_bit  = data_reg[idx_inc];
  assign last_bit  = (bit_idx == LAST_IDX);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer, one serial bit per CLK: start, data LSB-first, optional parity, stop.
// Optional second stop bit (STP2 port) when UART_TX_TWO_STOP_EN is defined.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | line high, waiting for Data_Valid
// ST_START  | start bit (low) on the line
// ST_DATA   | data bits, LSB first
// ST_PARITY | parity bit from the latched word and type
// ST_STOP   | stop bit(s), line high
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
`ifdef UART_TX_TWO_STOP_EN
  ,
  input  logic                  STP2
`endif
);

  uart_state_t state, state_nxt;
  logic        tx_nxt;
  logic        advance;
  logic        accept;
  logic        par_en_r, par_bit_r;
  logic        first_bit, next_bit, last_bit;
`ifdef UART_TX_TWO_STOP_EN
  logic        stp2_r, stop_hold;
`endif

  assign accept = (state == ST_IDLE) && Data_Valid;

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .CLK       (CLK),
    .RST       (RST),
    .load      (accept),
    .advance   (advance),
    .p_data    (P_DATA),
    .first_bit (first_bit),
    .next_bit  (next_bit),
    .last_bit  (last_bit)
  );

  always_comb begin
    state_nxt = ST_IDLE;
    tx_nxt    = IDLE_LEVEL;
    advance   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Data_Valid) begin
          state_nxt = ST_START;
          tx_nxt    = START_BIT;
        end
      end
      ST_START: begin
        state_nxt = ST_DATA;
        tx_nxt    = first_bit;
      end
      ST_DATA: begin
        if (!last_bit) begin
          state_nxt = ST_DATA;
          tx_nxt    = next_bit;
          advance   = 1'b1;
        end else if (par_en_r) begin
          state_nxt = ST_PARITY;
          tx_nxt    = par_bit_r;
        end else begin
          state_nxt = ST_STOP;
          tx_nxt    = STOP_BIT;
        end
      end
      ST_PARITY: begin
        state_nxt = ST_STOP;
        tx_nxt    = STOP_BIT;
      end
      ST_STOP: begin
`ifdef UART_TX_TWO_STOP_EN
        if (stp2_r && !stop_hold) begin
          state_nxt = ST_STOP;
          tx_nxt    = STOP_BIT;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      TX_OUT    <= IDLE_LEVEL;
      busy      <= 1'b0;
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      TX_OUT <= tx_nxt;
      busy   <= (state_nxt != ST_IDLE);
      if (accept) begin
        par_en_r  <= PAR_EN;
        par_bit_r <= (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;
      end
    end
  end

`ifdef UART_TX_TWO_STOP_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stp2_r    <= 1'b0;
      stop_hold <= 1'b0;
    end else begin
      if (accept) stp2_r <= STP2;
      stop_hold <= (state == ST_STOP) && (state_nxt == ST_STOP);
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: expected frames are queued at stimulus time and
// compared against the captured serial line when busy drops. Honours UART_TX_TWO_STOP_EN.
module tb_uart_tx_frame;

  typedef struct {
    int          len;
    logic [15:0] bits;
    int          gap;
  } frame_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT;
  logic       busy;
`ifdef UART_TX_TWO_STOP_EN
  logic       STP2 = 1'b0;
`endif

  frame_t      exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_unexp = 0;
  bit          in_frame = 0;
  int          cur_len = 0;
  int          idle_cnt = 0;
  int          gap_seen = 0;
  logic [15:0] got_bits = '0;

  always #5 CLK = ~CLK;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
`ifdef UART_TX_TWO_STOP_EN
    ,
    .STP2       (STP2)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic frame_t make_frame(input logic [7:0] d, input logic pe, input logic pt,
                                        input logic s2, input int gap);
    frame_t f;
    int n;
    f.bits = '0;
    f.bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      f.bits[n] = d[i];
      n++;
    end
    if (pe) begin
      f.bits[n] = pt ? ~^d : ^d;
      n++;
    end
    f.bits[n] = 1'b1;
    n++;
    if (s2) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.len = n;
    f.gap = gap;
    return f;
  endfunction

  // Frame capture: busy high marks the frame, the first busy-low sample closes it.
  always @(negedge CLK) begin
    if (!RST) begin
      in_frame = 0;
      cur_len  = 0;
      idle_cnt = 0;
    end else if (busy) begin
      if (!in_frame) begin
        in_frame = 1;
        cur_len  = 0;
        got_bits = '0;
        gap_seen = idle_cnt;
      end
      if (cur_len < 16) got_bits[cur_len] = TX_OUT;
      cur_len++;
    end else begin
      if (in_frame) begin
        in_frame = 0;
        if (exp_q.size() == 0) begin
          n_unexp++;
        end else begin
          frame_t e;
          e = exp_q.pop_front();
          check_val("frame_len", cur_len, e.len);
          check_val("frame_bits", got_bits, e.bits);
          check_val("idle_after", TX_OUT, 1);
          if (e.gap >= 0) check_val("idle_gap", gap_seen, e.gap);
        end
        idle_cnt = 0;
      end
      idle_cnt++;
    end
  end

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
    @(negedge CLK);
    P_DATA = d;
    PAR_EN = pe;
    PAR_TYP = pt;
`ifdef UART_TX_TWO_STOP_EN
    STP2 = s2;
`endif
    Data_Valid = 1'b1;
    exp_q.push_back(make_frame(d, pe, pt, s2, -1));
    @(posedge CLK);
    @(negedge CLK);
    Data_Valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || in_frame) && k < 60) begin
      @(negedge CLK);
      k++;
    end
    if (k >= 60) check_val("frame_timeout", exp_q.size(), 0);
    @(negedge CLK);
  endtask

  initial begin
    int bad;
    frame_t f;

    repeat (3) @(negedge CLK);
    check_val("rst_tx", TX_OUT, 1);
    check_val("rst_busy", busy, 0);
    RST = 1'b1;
    @(negedge CLK);
    check_val("post_rst_tx", TX_OUT, 1);
    check_val("post_rst_busy", busy, 0);

    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (busy !== 1'b0 || TX_OUT !== 1'b1) bad++;
    end
    check_val("quiet_idle", bad, 0);

    send(8'hA5, 1'b0, 1'b0, 1'b0);
    wait_done();
    send(8'h0F, 1'b1, 1'b0, 1'b0);
    wait_done();
    send(8'h0F, 1'b1, 1'b1, 1'b0);
    wait_done();
    send(8'h07, 1'b1, 1'b0, 1'b0);
    wait_done();

    // Mid-frame Data_Valid and input changes must not disturb the 8'h3C frame.
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    P_DATA = 8'hFF;
    PAR_EN = 1'b1;
    Data_Valid = 1'b1;
    @(negedge CLK);
    PAR_EN = 1'b0;
    @(negedge CLK);
    PAR_EN = 1'b1;
    Data_Valid = 1'b0;
    @(negedge CLK);
    PAR_EN = 1'b0;
    wait_done();
    repeat (15) @(negedge CLK);
    check_val("no_second_frame", n_unexp, 0);

    // Abort during data bit 3.
    send(8'hC3, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    #1;
    check_val("abort_tx", TX_OUT, 1);
    check_val("abort_busy", busy, 0);
    void'(exp_q.pop_front());
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    send(8'h55, 1'b0, 1'b0, 1'b0);
    wait_done();

    // Data_Valid held high across three back-to-back frames.
    @(negedge CLK);
    P_DATA = 8'h81;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    Data_Valid = 1'b1;
    exp_q.push_back(make_frame(8'h81, 1'b0, 1'b0, 1'b0, -1));
    f = make_frame(8'h81, 1'b0, 1'b0, 1'b0, 1);
    exp_q.push_back(f);
    exp_q.push_back(f);
    repeat (23) @(posedge CLK);
    @(negedge CLK);
    Data_Valid = 1'b0;
    wait_done();

`ifdef UART_TX_TWO_STOP_EN
    send(8'h81, 1'b0, 1'b0, 1'b1);
    wait_done();
    send(8'h0F, 1'b1, 1'b1, 1'b1);
    wait_done();
    STP2 = 1'b0;
`endif

    repeat (12) @(negedge CLK);
    check_val("unexpected_frames", n_unexp, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmit framer, the transmit counterpart of the UART receive path. It accepts one parallel data word per Data_Valid handshake and serialises it at one bit per CLK cycle: start bit, data LSB-first, optional parity, then stop bit. CLK is the TX baud-rate clock from the system clock divider. Busy back-pressures the upstream TX FIFO read logic.

Parameters:
DATA_WIDTH, 8, payload bits per frame (bit index counter width = $clog2(DATA_WIDTH))

Ports:
CLK  input  1  TX baud clock, one serial bit per cycle
RST  input  1  asynchronous active-low reset
P_DATA  input  DATA_WIDTH  parallel word; sampled only at acceptance
Data_Valid  input  1  word-available strobe; accepted only in IDLE
PAR_EN  input  1  1 = parity bit inserted; sampled at acceptance
PAR_TYP  input  1  0 = even, 1 = odd; sampled at acceptance
TX_OUT  output  1  serial line, registered, idle-high
busy  output  1  high while a frame is in flight, registered

Behaviour:
- Reset (async, RST=0): state IDLE, TX_OUT=1, busy=0, bit index=0, data/parity holding regs=0. Assertion mid-frame aborts the frame immediately; no partial-frame completion.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, busy=0. At an edge with Data_Valid=1, latch P_DATA, PAR_EN, PAR_TYP and compute the parity bit; go to START. After this edge TX_OUT=0 and busy=1 (zero-cycle output latency from acceptance edge).
- START: one cycle with TX_OUT=0; then DATA with bit index=0.
- DATA: TX_OUT=data[index], one cycle per bit, LSB first. Index increments each cycle. At index=DATA_WIDTH-1, go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: one cycle. TX_OUT = ^data when even, ~^data when odd.
- STOP: one cycle with TX_OUT=1, then IDLE. busy=0 after that edge.
- Frame length: DATA_WIDTH+2 cycles, or +3 with parity. busy is high for exactly that many cycles.
- Data_Valid while busy=1 is ignored: no queuing, no latching, no effect on the current frame.
- Changes to P_DATA/PAR_EN/PAR_TYP mid-frame have no effect; only the latched copies are used.
- Data_Valid held high continuously: frames separated by exactly one idle cycle (TX_OUT=1), since acceptance happens only in IDLE.
- Illegal state encoding: recover to IDLE next cycle with TX_OUT=1, busy=0.
- TX_OUT and busy are driven from flops only; no combinational path from inputs to outputs.

Optional Feature:
Macro UART_TX_TWO_STOP_EN.
- Defined: adds input STP2 (1 bit), latched at acceptance. When latched STP2=1, STOP lasts two cycles (TX_OUT=1), so frame and busy are one cycle longer. When STP2=0, behaviour is identical to the undefined case.
- Undefined: no STP2 port; exactly one stop cycle.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE/START/DATA/PARITY/STOP, 3-bit);
  - constants PAR_EVEN=0, PAR_ODD=1;
  - START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
- Sub-module uart_tx_serializer: holds the latched word and bit index, and provides the current data bit and last-bit flag. The FSM, parity calculation and output register stay in the top module.

Test Plan:
- Reset with RST=0 for 3 cycles, then release -> TX_OUT=1, busy=0. No activity with Data_Valid=0 for 20 cycles.
- P_DATA=8'hA5, PAR_EN=0, one-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1. busy high exactly 10 cycles, then TX_OUT=1.
- P_DATA=8'h0F, PAR_EN=1: PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1. 11-cycle frames. P_DATA=8'h07 even -> parity 1.
- Start 8'h3C frame, then pulse Data_Valid with P_DATA=8'hFF and toggle PAR_EN during DATA -> transmitted frame is still 8'h3C without parity. No second frame follows.
- Assert RST during DATA bit 3 -> TX_OUT=1 and busy=0 immediately. After release, Data_Valid with 8'h55 -> clean 10-cycle frame.
- Data_Valid held high with 8'h81, PAR_EN=0 for 3 frames -> each frame 10 cycles, exactly 1 idle-high cycle between frames. With UART_TX_TWO_STOP_EN and STP2=1 -> 2 stop cycles, busy high 11 cycles.
